// File: rtl/decode_queue.sv
// Decode stage: circular instruction buffer feeding a registered RV32I decode slot
// handed to dispatch over a valid/ready handshake, with synchronous flush.
module decode_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3,
    parameter int unsigned TYPE_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              fetch_valid,
    input  logic [31:0]       fetch_ins,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [TYPE_W-1:0] out_type,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic              out_rs1_used,
    output logic              out_rs2_used,
    output logic              out_writes_rd,
    output logic              out_is_lsu,
    output logic              out_is_branch,
    output logic              out_is_store,
    output logic              out_illegal,
    output logic [PTR_W:0]    count
);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Instruction type codes; 0 is reserved for illegal encodings.
    localparam logic [TYPE_W-1:0]
        T_LUI  = TYPE_W'(1),  T_AUIPC = TYPE_W'(2),  T_JAL   = TYPE_W'(3),  T_JALR  = TYPE_W'(4),
        T_BEQ  = TYPE_W'(5),  T_BNE   = TYPE_W'(6),  T_BLT   = TYPE_W'(7),  T_BGE   = TYPE_W'(8),
        T_BLTU = TYPE_W'(9),  T_BGEU  = TYPE_W'(10), T_LB    = TYPE_W'(11), T_LH    = TYPE_W'(12),
        T_LW   = TYPE_W'(13), T_LBU   = TYPE_W'(14), T_LHU   = TYPE_W'(15), T_SB    = TYPE_W'(16),
        T_SH   = TYPE_W'(17), T_SW    = TYPE_W'(18), T_ADDI  = TYPE_W'(19), T_SLTI  = TYPE_W'(20),
        T_SLTIU= TYPE_W'(21), T_XORI  = TYPE_W'(22), T_ORI   = TYPE_W'(23), T_ANDI  = TYPE_W'(24),
        T_SLLI = TYPE_W'(25), T_SRLI  = TYPE_W'(26), T_SRAI  = TYPE_W'(27), T_ADD   = TYPE_W'(28),
        T_SUB  = TYPE_W'(29), T_SLL   = TYPE_W'(30), T_SLT   = TYPE_W'(31), T_SLTU  = TYPE_W'(32),
        T_XOR  = TYPE_W'(33), T_SRL   = TYPE_W'(34), T_SRA   = TYPE_W'(35), T_OR    = TYPE_W'(36),
        T_AND  = TYPE_W'(37), T_FENCE = TYPE_W'(38), T_ECALL = TYPE_W'(39), T_EBREAK= TYPE_W'(40);

    logic [31:0]       ins_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, load;

    logic [31:0]       head_ins;
    logic [ADDR_W-1:0] head_pc;
    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [TYPE_W-1:0] d_type;
    logic [31:0]       d_imm;
    logic              d_rs1u, d_rs2u, d_lsu, d_br, d_st, d_ill;

    assign fetch_ready = (count < CNT_W'(DEPTH));
    assign push = rdy_in & fetch_valid & fetch_ready & ~flush_in;
    assign load = rdy_in & ~flush_in & (count != '0) & (~out_valid | out_ready);

    assign head_ins = ins_mem[rd_ptr];
    assign head_pc  = pc_mem[rd_ptr];
    assign opc      = head_ins[6:0];
    assign f3       = head_ins[14:12];
    assign f7       = head_ins[31:25];
    assign imm_i    = {{20{head_ins[31]}}, head_ins[31:20]};
    assign imm_s    = {{20{head_ins[31]}}, head_ins[31:25], head_ins[11:7]};
    assign imm_b    = {{19{head_ins[31]}}, head_ins[31], head_ins[7], head_ins[30:25], head_ins[11:8], 1'b0};
    assign imm_u    = {head_ins[31:12], 12'b0};
    assign imm_j    = {{11{head_ins[31]}}, head_ins[31], head_ins[19:12], head_ins[20], head_ins[30:21], 1'b0};
    assign imm_sh   = {27'b0, head_ins[24:20]};

    // Head-entry decode; illegal encodings collapse to a neutral record.
    always_comb begin
        d_type = '0; d_imm = '0; d_rs1u = 1'b1; d_rs2u = 1'b0;
        d_lsu = 1'b0; d_br = 1'b0; d_st = 1'b0; d_ill = 1'b0;
        case (opc)
            7'h37: begin d_type = T_LUI;   d_imm = imm_u; d_rs1u = 1'b0; end
            7'h17: begin d_type = T_AUIPC; d_imm = imm_u; d_rs1u = 1'b0; end
            7'h6F: begin d_type = T_JAL;   d_imm = imm_j; d_rs1u = 1'b0; end
            7'h67: begin d_type = T_JALR;  d_imm = imm_i; d_ill = (f3 != 3'b000); end
            7'h63: begin
                d_br = 1'b1; d_rs2u = 1'b1; d_imm = imm_b;
                case (f3)
                    3'b000: d_type = T_BEQ;
                    3'b001: d_type = T_BNE;
                    3'b100: d_type = T_BLT;
                    3'b101: d_type = T_BGE;
                    3'b110: d_type = T_BLTU;
                    3'b111: d_type = T_BGEU;
                    default: d_ill = 1'b1;
                endcase
            end
            7'h03: begin
                d_lsu = 1'b1; d_imm = imm_i;
                case (f3)
                    3'b000: d_type = T_LB;
                    3'b001: d_type = T_LH;
                    3'b010: d_type = T_LW;
                    3'b100: d_type = T_LBU;
                    3'b101: d_type = T_LHU;
                    default: d_ill = 1'b1;
                endcase
            end
            7'h23: begin
                d_lsu = 1'b1; d_st = 1'b1; d_rs2u = 1'b1; d_imm = imm_s;
                case (f3)
                    3'b000: d_type = T_SB;
                    3'b001: d_type = T_SH;
                    3'b010: d_type = T_SW;
                    default: d_ill = 1'b1;
                endcase
            end
            7'h13: begin
                d_imm = imm_i;
                case (f3)
                    3'b000: d_type = T_ADDI;
                    3'b010: d_type = T_SLTI;
                    3'b011: d_type = T_SLTIU;
                    3'b100: d_type = T_XORI;
                    3'b110: d_type = T_ORI;
                    3'b111: d_type = T_ANDI;
                    3'b001: begin d_imm = imm_sh; d_type = T_SLLI; d_ill = (f7 != 7'h00); end
                    default: begin
                        d_imm = imm_sh;
                        if (f7 == 7'h00)      d_type = T_SRLI;
                        else if (f7 == 7'h20) d_type = T_SRAI;
                        else                  d_ill = 1'b1;
                    end
                endcase
            end
            7'h33: begin
                d_rs2u = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'b000}: d_type = T_ADD;
                    {7'h20, 3'b000}: d_type = T_SUB;
                    {7'h00, 3'b001}: d_type = T_SLL;
                    {7'h00, 3'b010}: d_type = T_SLT;
                    {7'h00, 3'b011}: d_type = T_SLTU;
                    {7'h00, 3'b100}: d_type = T_XOR;
                    {7'h00, 3'b101}: d_type = T_SRL;
                    {7'h20, 3'b101}: d_type = T_SRA;
                    {7'h00, 3'b110}: d_type = T_OR;
                    {7'h00, 3'b111}: d_type = T_AND;
                    default: d_ill = 1'b1;
                endcase
            end
            7'h0F: begin d_type = T_FENCE; d_imm = imm_i; d_ill = (f3 != 3'b000); end
            7'h73: begin
                d_imm = imm_i;
                if (head_ins == 32'h0000_0073)      d_type = T_ECALL;
                else if (head_ins == 32'h0010_0073) d_type = T_EBREAK;
                else                                d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_type = '0; d_imm = '0; d_rs1u = 1'b0; d_rs2u = 1'b0;
            d_lsu = 1'b0; d_br = 1'b0; d_st = 1'b0;
        end
    end

    // Buffer storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_in) begin
        if (push) begin
            ins_mem[wr_ptr] <= fetch_ins;
            pc_mem[wr_ptr]  <= fetch_pc;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; out_valid <= 1'b0;
            out_pc <= '0; out_type <= '0; out_imm <= '0;
            out_rd <= '0; out_rs1 <= '0; out_rs2 <= '0;
            out_rs1_used <= 1'b0; out_rs2_used <= 1'b0; out_writes_rd <= 1'b0;
            out_is_lsu <= 1'b0; out_is_branch <= 1'b0; out_is_store <= 1'b0; out_illegal <= 1'b0;
        end else if (flush_in) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; out_valid <= 1'b0;
        end else if (rdy_in) begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                out_valid     <= 1'b1;
                out_pc        <= head_pc;
                out_type      <= d_type;
                out_imm       <= d_imm;
                out_rd        <= head_ins[11:7];
                out_rs1       <= d_rs1u ? head_ins[19:15] : 5'd0;
                out_rs2       <= d_rs2u ? head_ins[24:20] : 5'd0;
                out_rs1_used  <= d_rs1u;
                out_rs2_used  <= d_rs2u;
                out_writes_rd <= (head_ins[11:7] != 5'd0) & ~d_st & ~d_br & ~d_ill;
                out_is_lsu    <= d_lsu;
                out_is_branch <= d_br;
                out_is_store  <= d_st;
                out_illegal   <= d_ill;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: driver feeds a queue-level reference model,
// monitor pops expected decodes at every dispatch handshake.
module tb_decode_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  typ;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  fl;   // rs1_used, rs2_used, writes_rd, is_lsu, is_branch, is_store, illegal
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, fetch_valid, fetch_ready, out_ready, out_valid;
    logic [31:0] fetch_ins, fetch_pc, out_pc, out_imm;
    logic [5:0]  out_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rs1_used, out_rs2_used, out_writes_rd, out_is_lsu, out_is_branch, out_is_store, out_illegal;
    logic [3:0]  count;

    decode_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .fetch_valid(fetch_valid), .fetch_ins(fetch_ins), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_type(out_type),
        .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used), .out_writes_rd(out_writes_rd),
        .out_is_lsu(out_is_lsu), .out_is_branch(out_is_branch), .out_is_store(out_is_store),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk_in = ~clk_in;

    int   total = 0, bad = 0;
    exp_t sb[$];
    int   mcount = 0;
    bit   slot_v = 1'b0;
    int   exp_count = 0;
    bit   exp_valid = 1'b0, exp_fr = 1'b1, mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder built from opcode tables rather than per-field muxing.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int btab[8] = '{5, 6, -1, -1, 7, 8, 9, 10};
        int ltab[8] = '{11, 12, 13, -1, 14, 15, -1, -1};
        int itab[8] = '{19, -1, 20, 21, 22, -1, 23, 24};
        int rtab[8] = '{28, 30, 31, 32, 33, 34, 36, 37};
        int t = 0;
        logic [31:0] imm = 0;
        bit u1 = 1, u2 = 0, ls = 0, br = 0, st = 0, ok = 1, wr;
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        logic [31:0] im_i = 32'($signed(i[31:20]));
        case (i[6:0])
            7'h37: begin t = 1; imm = {i[31:12], 12'h0}; u1 = 0; end
            7'h17: begin t = 2; imm = {i[31:12], 12'h0}; u1 = 0; end
            7'h6F: begin t = 3; u1 = 0; imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin t = (f3 == 0) ? 4 : -1; imm = im_i; end
            7'h63: begin t = btab[f3]; br = 1; u2 = 1; imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h03: begin t = ltab[f3]; ls = 1; imm = im_i; end
            7'h23: begin t = (f3 < 3) ? 16 + int'(f3) : -1; ls = 1; st = 1; u2 = 1;
                         imm = 32'($signed({i[31:25], i[11:7]})); end
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    imm = 32'(i[24:20]);
                    if (f7 == 0) t = (f3 == 1) ? 25 : 26;
                    else if (f7 == 7'h20 && f3 == 5) t = 27;
                    else t = -1;
                end else begin
                    t = itab[f3]; imm = im_i;
                end
            end
            7'h33: begin
                u2 = 1;
                if (f7 == 0) t = rtab[f3];
                else if (f7 == 7'h20 && f3 == 0) t = 29;
                else if (f7 == 7'h20 && f3 == 5) t = 35;
                else t = -1;
            end
            7'h0F: begin t = (f3 == 0) ? 38 : -1; imm = im_i; end
            7'h73: begin imm = im_i; t = (i == 32'h73) ? 39 : (i == 32'h0010_0073) ? 40 : -1; end
            default: t = -1;
        endcase
        ok = (t > 0);
        if (!ok) begin t = 0; imm = 0; u1 = 0; u2 = 0; ls = 0; br = 0; st = 0; end
        wr = (i[11:7] != 0) && !st && !br && ok;
        e.pc = pc; e.typ = 6'(t); e.imm = imm; e.rd = i[11:7];
        e.rs1 = u1 ? i[19:15] : 5'd0;
        e.rs2 = u2 ? i[24:20] : 5'd0;
        e.fl = {u1, u2, wr, ls, br, st, !ok};
        return e;
    endfunction

    function automatic logic [31:0] gen_ins();
        logic [6:0] ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] i;
        int k;
        i = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) begin
            i[6:0] = ops[k];
            case ($urandom_range(0, 3))
                0: i[31:25] = 7'h00;
                1: i[31:25] = 7'h20;
                default: ;
            endcase
        end else if (k == 11) begin
            i = ($urandom_range(0, 1) != 0) ? 32'h0000_0073 : 32'h0010_0073;
        end
        return i;
    endfunction

    // Drive one cycle at the falling edge and advance the model to the next rising edge.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit rdy, input bit fl);
        bit pushok, loadok;
        @(negedge clk_in);
        fetch_valid = v; fetch_ins = ins; fetch_pc = pc;
        out_ready = ordy; rdy_in = rdy; flush_in = fl;
        exp_count = mcount; exp_valid = slot_v; exp_fr = (mcount < DEPTH);
        if (fl) begin
            mcount = 0; slot_v = 0; sb.delete();
        end else if (rdy) begin
            pushok = v && (mcount < DEPTH);
            loadok = (mcount > 0) && (!slot_v || ordy);
            if (loadok) begin mcount--; slot_v = 1; end
            else if (slot_v && ordy) slot_v = 0;
            if (pushok) begin mcount++; sb.push_back(ref_dec(ins, pc)); end
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 32'h0, 32'h0, ordy, 1, 0);
    endtask

    // Push one instruction into an empty pipe and stall it in the slot for inspection.
    task automatic show(input logic [31:0] ins, input logic [31:0] pc);
        cycle(1, ins, pc, 1, 1, 0);
        idle(0);
        idle(0);
        #2;
    endtask

    task automatic check_slot(input string name, input logic [5:0] t, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] fl);
        chk(name, {out_valid, out_type, out_imm, out_rd, out_rs1, out_rs2, out_rs1_used, out_rs2_used,
                   out_writes_rd, out_is_lsu, out_is_branch, out_is_store, out_illegal},
                  {1'b1, t, imm, rd, rs1, rs2, fl});
    endtask

    // Monitor: compares state every cycle and pops the scoreboard on each handshake.
    always begin
        exp_t e;
        @(negedge clk_in);
        #1;
        if (mon_en) begin
            chk("count", 128'(count), 128'(exp_count));
            chk("out_valid", 128'(out_valid), 128'(exp_valid));
            chk("fetch_ready", 128'(fetch_ready), 128'(exp_fr));
            if (out_valid && out_ready && rdy_in && !flush_in) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got pc %0h expected none", out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("slot", 128'({out_pc, out_type, out_imm, out_rd, out_rs1, out_rs2,
                                      out_rs1_used, out_rs2_used, out_writes_rd, out_is_lsu,
                                      out_is_branch, out_is_store, out_illegal}), 128'(e));
                end
            end
        end
    end

    initial begin
        rst_in = 0; rdy_in = 0; flush_in = 0; fetch_valid = 0; fetch_ins = 0; fetch_pc = 0; out_ready = 0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("reset_state", 128'({out_valid, count, out_pc, out_type, out_imm, out_rd, out_illegal, out_writes_rd}), 128'(0));
        chk("reset_fetch_ready", 128'(fetch_ready), 128'(1));
        @(negedge clk_in);
        rst_in = 1; rdy_in = 1;
        mon_en = 1;

        // ADDI latency and fields
        show(32'hFFD0_8293, 32'h100);
        check_slot("addi", 6'd19, 32'hFFFF_FFFD, 5'd5, 5'd1, 5'd0, 7'b1010000);
        idle(1); idle(1);

        // Fill past capacity with dispatch stalled, then drain in order
        for (int k = 0; k < DEPTH + 2; k++) cycle(1, gen_ins(), 32'h200 + 32'(4 * k), 0, 1, 0);
        for (int k = 0; k < DEPTH + 3; k++) idle(1);

        // Store and branch decode
        show(32'h0021_A423, 32'h300);
        check_slot("sw", 6'd18, 32'd8, 5'd8, 5'd3, 5'd2, 7'b1101010);
        idle(1); idle(1);
        show(32'h0020_8863, 32'h304);
        check_slot("beq", 6'd5, 32'd16, 5'd16, 5'd1, 5'd2, 7'b1100100);
        idle(1); idle(1);

        // Flush with a concurrent push
        for (int k = 0; k < 6; k++) cycle(1, gen_ins(), 32'h400 + 32'(4 * k), 0, 1, 0);
        cycle(1, 32'hFFD0_8293, 32'h4FC, 0, 1, 1);
        for (int k = 0; k < 3; k++) idle(1);

        // Freeze
        for (int k = 0; k < 3; k++) cycle(1, gen_ins(), 32'h500 + 32'(4 * k), 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(1, gen_ins(), 32'h600 + 32'(4 * k), 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, gen_ins(), 32'h700 + 32'(4 * k), 1, 1, 0);
        for (int k = 0; k < 8; k++) idle(1);

        // Illegal encodings
        show(32'h1234_507F, 32'h800);
        check_slot("illegal_op", 6'd0, 32'd0, 5'd0, 5'd0, 5'd0, 7'b0000001);
        idle(1); idle(1);
        show(32'h0230_D293, 32'h804);
        check_slot("illegal_srai", 6'd0, 32'd0, 5'd5, 5'd0, 5'd0, 7'b0000001);
        idle(1); idle(1);

        // Back-to-back streaming across pointer wrap
        for (int k = 0; k < 20; k++) cycle(1, gen_ins(), 32'h900 + 32'(4 * k), 1, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++)
            cycle(($urandom % 10) < 7, gen_ins(), $urandom, ($urandom % 10) < 7,
                  ($urandom % 10) < 9, ($urandom % 50) == 0);

        for (int k = 0; k < 30 && (mcount > 0 || slot_v); k++) idle(1);
        idle(1);
        idle(1);
        #2;
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised decode stage with an instruction buffer, sitting between the fetcher and the rename/dispatch logic (ROB, RS, LSU).
- Buffers up to DEPTH fetched instructions in a circular queue.
- Decodes the head instruction into a registered output slot.
- Hands the slot to dispatch with a valid/ready handshake.
- Supports a synchronous flush on branch misprediction.
- Unlike a purely combinational decoder, it decouples fetch from back-end stalls and flags illegal encodings.

Parameters:
ADDR_W, 32, PC width
DEPTH, 8, queue entries; power of two, >= 2
PTR_W, 3, log2(DEPTH)
TYPE_W, 6, instruction-type code width (type codes from the shared definitions header)

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low freezes all state except flush
flush_in  in  1  synchronous flush (misprediction)
fetch_valid  in  1  fetcher offers an instruction
fetch_ins  in  32  raw instruction
fetch_pc  in  ADDR_W  instruction PC
fetch_ready  out  1  queue can accept this cycle
out_ready  in  1  dispatch accepts the slot (ROB/RS/LSU not full)
out_valid  out  1  slot holds a decoded instruction
out_pc  out  ADDR_W  PC
out_type  out  TYPE_W  type code
out_imm  out  32  decoded immediate
out_rd  out  5  destination register
out_rs1  out  5  source 1 (0 if unused)
out_rs2  out  5  source 2 (0 if unused)
out_rs1_used  out  1  rs1 is a true operand
out_rs2_used  out  1  rs2 is a true operand
out_writes_rd  out  1  reserve rd in ROB
out_is_lsu  out  1  load or store (route to LSU, else RS)
out_is_branch  out  1  conditional branch
out_is_store  out  1  store (ROB entry ready at dispatch)
out_illegal  out  1  unsupported opcode/funct
count  out  PTR_W+1  occupied queue entries, excluding the slot

Behaviour:
- Reset (rst_in=0, asynchronous):
  - Pointers, count and out_valid clear to 0; all out_* fields clear to 0.
  - fetch_ready is 1 once reset releases.
- fetch_ready = (count < DEPTH); depends on count only, with no combinational path from out_ready.
- Push: at an edge with rdy_in & fetch_valid & fetch_ready & !flush_in, write {ins, pc} at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
- Slot load: at an edge with rdy_in & !flush_in & (count>0) & (!out_valid | out_ready):
  - decode the entry at rd_ptr into the out_* registers;
  - set out_valid=1; rd_ptr increments, wrapping.
- Slot drain: out_valid & out_ready & no load that cycle -> out_valid=0.
- Simultaneous push and load: count unchanged. Push only: count+1. Load only: count-1.
- Latency:
  - An instruction pushed at edge k into an empty queue with the slot free or draining appears with out_valid=1 after edge k+1.
  - Sustained throughput is 1 instruction/cycle.
- Slot hold: while out_valid & !out_ready, all out_* fields hold stable.
- Freeze: rdy_in=0 blocks push, load and drain; the entire state holds.
- Flush (flush_in=1 at an edge, regardless of rdy_in):
  - pointers and count go to 0; out_valid goes to 0;
  - a concurrent push is dropped;
  - the out_* data fields need not clear.
- Decode rules:
  - rs1 unused for LUI/AUIPC/JAL.
  - rs2 used only for branch, store and R-type.
  - Unused rs fields are forced to 0.
  - writes_rd = (rd != 0) & !store & !branch & !illegal.
- Immediates:
  - U-type: {ins[31:12], 12'b0}.
  - J-type: sign-extended {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - I-type, JALR and load: sign-extended ins[31:20].
  - Shift-immediate (funct3 001/101): zero-extended ins[24:20].
  - B-type: sign-extended {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - S-type: sign-extended {ins[31:25], ins[11:7]}.
- Illegal:
  - Any opcode outside the RV32I base set, or an undefined funct3/funct7 within it, gives out_illegal=1 with out_type=0, writes_rd=0, is_lsu=0, imm=0.
  - It still issues, so the ROB can trap in order.
- Wrap-around: after DEPTH pushes and DEPTH loads, both pointers return to 0 with no entry corrupted.

Test Plan:
1. Reset then push ADDI x5,x1,-3 (0xFFD08293) at PC 0x100, out_ready=1 -> after 2 edges out_valid=1, type=ADDI, imm=0xFFFFFFFD, rd=5, rs1=1, rs1_used=1, rs2=0, rs2_used=0, writes_rd=1, is_lsu=0.
2. Hold out_ready=0, push DEPTH+1 instructions -> slot holds the first, count=8, fetch_ready=0, the 10th offer is not accepted; raising out_ready drains all 9 in push order, one per cycle.
3. SW x2,8(x3) (0x0021A423) -> is_lsu=1, is_store=1, writes_rd=0, rs2_used=1, imm=8; BEQ with rd field nonzero -> writes_rd=0, is_branch=1.
4. With 5 entries queued and the slot valid, assert flush_in together with fetch_valid -> next cycle count=0, out_valid=0, fetch_ready=1; the flushed-cycle instruction never appears.
5. rdy_in=0 for 3 cycles with fetch_valid=1 and out_ready=1 -> count, pointers and out_* unchanged; streaming resumes when rdy_in=1.
6. Opcode 0x7F, and SRAI with funct7=0x01 -> out_illegal=1, out_type=0, writes_rd=0; 20 back-to-back push/load cycles -> pointer wrap, in-order, no loss.
